// File: rtl/pair_triple_event_counter_pkg.sv
// Shared definitions for the pair/triple event counter: qualifier FSM
// state encodings, run counter width and default parameter values.
package pair_triple_event_counter_pkg;

    // Qualifier FSM states. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } qual_state_e;

    // Run counter must hold values up to the largest legal p_min_high (15).
    localparam int unsigned RUN_NBITS = 4;

    // Default parameter values.
    localparam int unsigned DEF_COUNT_NBITS = 8;
    localparam int unsigned DEF_MIN_HIGH    = 2;
    localparam int unsigned DEF_THRESH      = 10;

    // True when one more consecutive high sample completes the run.
    function automatic logic run_complete(input logic [RUN_NBITS-1:0] run_next,
                                          input logic [RUN_NBITS-1:0] min_high);
        return (run_next == min_high);
    endfunction

endpackage

// File: rtl/pair_triple_qualifier.sv
// Debounce FSM for the detector output. Counts consecutive valid high
// samples (det_val=0 cycles neither advance nor break a run) and flags the
// sample that completes a run of p_min_high highs. qual_o is asserted
// combinationally during the qualifying sample; the top registers it.
module pair_triple_qualifier
    import pair_triple_event_counter_pkg::*;
#(
    parameter int unsigned p_min_high = DEF_MIN_HIGH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic det_i,
    input  logic det_val_i,
    output logic qual_o
);

    localparam logic [RUN_NBITS-1:0] MIN_HIGH_C = RUN_NBITS'(p_min_high);
    localparam logic [RUN_NBITS-1:0] RUN_ONE_C  = 4'd1;
    localparam logic [RUN_NBITS-1:0] RUN_ZERO_C = 4'd0;

    qual_state_e            state_q, state_d;
    logic [RUN_NBITS-1:0]   run_q, run_d;
    logic [RUN_NBITS-1:0]   run_inc_s;

    // State and run counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            run_q   <= RUN_ZERO_C;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next-state, run counter update and qualifying-sample strobe.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        qual_o    = 1'b0;
        run_inc_s = run_q + RUN_ONE_C;
        case (state_q)
            ST_IDLE: begin
                if (det_val_i && det_i) begin
                    if (MIN_HIGH_C == RUN_ONE_C) begin
                        qual_o  = 1'b1;
                        run_d   = RUN_ZERO_C;
                        state_d = ST_HOLD;
                    end else begin
                        run_d   = RUN_ONE_C;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (det_val_i && det_i) begin
                    if (run_complete(run_inc_s, MIN_HIGH_C)) begin
                        qual_o  = 1'b1;
                        run_d   = RUN_ZERO_C;
                        state_d = ST_HOLD;
                    end else begin
                        run_d   = run_inc_s;
                    end
                end else if (det_val_i) begin
                    run_d   = RUN_ZERO_C;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                // A continuous high yields one event; wait for a valid low.
                if (det_val_i && !det_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = RUN_ZERO_C;
            end
        endcase
    end

endmodule

// File: rtl/pair_triple_event_counter.sv
// Pair/triple event counter: debounces the detector output, counts each
// qualified assertion and raises a sticky alarm at a programmable threshold.
// Optional build macro PAIR_TRIPLE_COUNTER_SAT_EN: when defined the count
// saturates at its maximum; otherwise it wraps to zero (alarm stays set).
module pair_triple_event_counter
    import pair_triple_event_counter_pkg::*;
#(
    parameter int unsigned p_count_nbits = DEF_COUNT_NBITS,
    parameter int unsigned p_min_high    = DEF_MIN_HIGH,
    parameter int unsigned p_thresh      = DEF_THRESH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     det_i,
    input  logic                     det_val_i,
    input  logic                     clear_i,
    output logic                     event_o,
    output logic [p_count_nbits-1:0] count_o,
    output logic                     alarm_o
);

    localparam logic [p_count_nbits-1:0] CNT_ZERO_C = {p_count_nbits{1'b0}};
    localparam logic [p_count_nbits-1:0] CNT_ONE_C  = {{(p_count_nbits-1){1'b0}}, 1'b1};
    localparam logic [p_count_nbits-1:0] CNT_MAX_C  = {p_count_nbits{1'b1}};
    localparam logic [p_count_nbits-1:0] THRESH_C   = p_count_nbits'(p_thresh);

    logic                     qual_s;
    logic [p_count_nbits-1:0] count_inc_s;
    logic                     event_q, event_d;
    logic [p_count_nbits-1:0] count_q, count_d;
    logic                     alarm_q, alarm_d;

    pair_triple_qualifier #(
        .p_min_high (p_min_high)
    ) u_qualifier (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .det_i     (det_i),
        .det_val_i (det_val_i),
        .qual_o    (qual_s)
    );

    // Next count, event and alarm; clear beats a simultaneous increment.
    always_comb begin
        count_inc_s = count_q + CNT_ONE_C;
`ifdef PAIR_TRIPLE_COUNTER_SAT_EN
        if (count_q == CNT_MAX_C) begin
            count_inc_s = CNT_MAX_C;
        end else begin
            count_inc_s = count_q + CNT_ONE_C;
        end
`endif
        event_d = qual_s;
        count_d = count_q;
        alarm_d = alarm_q;
        if (clear_i) begin
            count_d = CNT_ZERO_C;
            alarm_d = 1'b0;
        end else if (qual_s) begin
            count_d = count_inc_s;
            alarm_d = alarm_q | (count_inc_s >= THRESH_C);
        end else begin
            count_d = count_q;
            alarm_d = alarm_q;
        end
    end

    // Output registers; reset overrides clear and any pending event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_q <= 1'b0;
            count_q <= CNT_ZERO_C;
            alarm_q <= 1'b0;
        end else begin
            event_q <= event_d;
            count_q <= count_d;
            alarm_q <= alarm_d;
        end
    end

    assign event_o = event_q;
    assign count_o = count_q;
    assign alarm_o = alarm_q;

endmodule

// File: tb/tb_pair_triple_event_counter.sv
// Scoreboard bench for pair_triple_event_counter. Two instances run on the
// same stimulus: the default configuration and a narrow one (4-bit count,
// single-sample qualification, threshold 3). A streak-based reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_pair_triple_event_counter;

    localparam int W0 = 8;
    localparam int MH0 = 2;
    localparam int TH0 = 10;
    localparam int W1 = 4;
    localparam int MH1 = 1;
    localparam int TH1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, det_i, det_val_i, clear_i;
    logic ev0, al0, ev1, al1;
    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;

    pair_triple_event_counter #(.p_count_nbits(W0), .p_min_high(MH0), .p_thresh(TH0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .det_i(det_i), .det_val_i(det_val_i),
        .clear_i(clear_i), .event_o(ev0), .count_o(cnt0), .alarm_o(al0));

    pair_triple_event_counter #(.p_count_nbits(W1), .p_min_high(MH1), .p_thresh(TH1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .det_i(det_i), .det_val_i(det_val_i),
        .clear_i(clear_i), .event_o(ev1), .count_o(cnt1), .alarm_o(al1));

    typedef struct packed {
        logic        ev;
        logic [15:0] cnt;
        logic        al;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int checks = 0;
    int failures = 0;

    // Reference model: length of the current streak of valid highs.
    int streak[2];
    int mcnt[2];
    bit mal[2];
    bit mev[2];

    task automatic model_step(input int k, input int w, input int mh, input int th,
                              input bit d, input bit v, input bit c, input bit r);
        int mx;
        mx = (1 << w) - 1;
        mev[k] = 1'b0;
        if (r) begin
            streak[k] = 0;
            mcnt[k] = 0;
            mal[k] = 1'b0;
        end else begin
            if (v && d) begin
                if (streak[k] < 1000) streak[k]++;
                mev[k] = (streak[k] == mh);
            end else if (v) begin
                streak[k] = 0;
            end
            if (c) begin
                mcnt[k] = 0;
                mal[k] = 1'b0;
            end else if (mev[k]) begin
`ifdef PAIR_TRIPLE_COUNTER_SAT_EN
                if (mcnt[k] < mx) mcnt[k]++;
`else
                mcnt[k] = (mcnt[k] + 1) % (mx + 1);
`endif
                if (mcnt[k] >= th) mal[k] = 1'b1;
            end
        end
    endtask

    // Drive one cycle, predict its outputs, queue the prediction after the edge.
    task automatic step(input bit d, input bit v, input bit c, input bit r);
        det_i = d;
        det_val_i = v;
        clear_i = c;
        rst_i = r;
        model_step(0, W0, MH0, TH0, d, v, c, r);
        model_step(1, W1, MH1, TH1, d, v, c, r);
        @(posedge clk);
        q0.push_back('{ev: mev[0], cnt: 16'(mcnt[0]), al: mal[0]});
        q1.push_back('{ev: mev[1], cnt: 16'(mcnt[1]), al: mal[1]});
        #1;
    endtask

    task automatic event_seq();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic spot(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare each DUT output against the queued prediction.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            if (ev0 !== e0.ev || cnt0 !== e0.cnt[W0-1:0] || al0 !== e0.al) begin
                failures++;
                $display("FAIL sb_dut0 t=%0t got ev=%b cnt=%0d al=%b expected ev=%b cnt=%0d al=%b",
                         $time, ev0, cnt0, al0, e0.ev, e0.cnt[W0-1:0], e0.al);
            end
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks++;
            if (ev1 !== e1.ev || cnt1 !== e1.cnt[W1-1:0] || al1 !== e1.al) begin
                failures++;
                $display("FAIL sb_dut1 t=%0t got ev=%b cnt=%0d al=%b expected ev=%b cnt=%0d al=%b",
                         $time, ev1, cnt1, al1, e1.ev, e1.cnt[W1-1:0], e1.al);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        det_i = 1'b0;
        det_val_i = 1'b0;
        clear_i = 1'b0;

        // Reset held with det high
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        spot("rst_event", 32'(ev0), 32'd0);
        spot("rst_count", 32'(cnt0), 32'd0);
        spot("rst_alarm", 32'(al0), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("rst_no_early_event", 32'(ev0), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("rst_first_event", 32'(ev0), 32'd1);
        spot("rst_first_count", 32'(cnt0), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Debounce pattern 1,0,1,1,1,1,0
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("debounce_event", 32'(ev0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("debounce_single_pulse", 32'(ev0), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        spot("debounce_count", 32'(cnt0), 32'd2);

        // det_val gaps inside a run
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        spot("gap_no_event", 32'(ev0), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("gap_event", 32'(ev0), 32'd1);
        spot("gap_count", 32'(cnt0), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a run (with clear also asserted)
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("midrst_no_event", 32'(ev0), 32'd0);
        spot("midrst_count0", 32'(cnt0), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        spot("midrst_event", 32'(ev0), 32'd1);
        spot("midrst_count1", 32'(cnt0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Threshold
        repeat (8) event_seq();
        spot("thresh_below_count", 32'(cnt0), 32'd9);
        spot("thresh_below_alarm", 32'(al0), 32'd0);
        event_seq();
        spot("thresh_count", 32'(cnt0), 32'd10);
        spot("thresh_alarm", 32'(al0), 32'd1);

        // Clear coincident with the 11th qualification
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        spot("clear_event", 32'(ev0), 32'd1);
        spot("clear_count", 32'(cnt0), 32'd0);
        spot("clear_alarm", 32'(al0), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Overflow of the 4-bit instance
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (17) event_seq();
`ifdef PAIR_TRIPLE_COUNTER_SAT_EN
        spot("overflow_count", 32'(cnt1), 32'd15);
`else
        spot("overflow_count", 32'(cnt1), 32'd1);
`endif
        spot("overflow_alarm", 32'(al1), 32'd1);
        spot("overflow_wide_count", 32'(cnt0), 32'd17);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit d, v, c, r;
            d = ($urandom % 10) < 6;
            v = ($urandom % 10) < 7;
            c = ($urandom % 50) == 0;
            r = ($urandom % 100) == 0;
            step(d, v, c, r);
        end

        // Drain the scoreboard
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", q0.size(), q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
